neuron_mac_q8_8: RTL and testbench
==================================

NEURON_MAC_Q8_8 -- requirements
Module: neuron_mac_q8_8

Interface
REQ-001 SHALL have parameter N_INPUTS, default 16, meaning multiply-accumulate beats per neuron evaluation (valid range 1..1024).
REQ-002 SHALL have parameter ACC_W, default 44, meaning accumulator width in bits (minimum 32+clog2(N_INPUTS)+1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin evaluation; bias sampled on the same edge.
REQ-006 bias  input  16  signed Q8.8 bias.
REQ-007 in_valid  input  1  x/w pair valid.
REQ-008 in_ready  output  1  block accepts x/w pair.
REQ-009 x  input  16  signed Q8.8 activation input.
REQ-010 w  input  16  signed Q8.8 weight.
REQ-011 out_valid  output  1  y valid for the downstream activation stage.
REQ-012 out_ready  input  1  downstream accepts y.
REQ-013 y  output  16  signed Q8.8 pre-activation result.
REQ-014 ovf  output  1  y was saturated; qualified by out_valid.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, ACCUM, FINAL, OUT.
REQ-017 IDLE: in_ready=0, out_valid=0; start=1 loads acc <= sign-extended bias <<< 8, clears beat counter, goes to ACCUM.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 ACCUM: in_ready=1; each edge with in_valid&in_ready adds the full 32-bit signed product x*w (Q16.16) to acc and increments the counter.
REQ-020 The handshake completing beat N_INPUTS SHALL move the FSM to FINAL; no further pairs are accepted (in_ready=0 from the next cycle).
REQ-021 in_valid=0 in ACCUM SHALL stall accumulation without state change; there is no timeout.
REQ-022 FINAL (one cycle): compute r = acc >>> 8 (arithmetic), apply rounding per REQ-031, saturate to [-32768, 32767], register into y and ovf, go to OUT.
REQ-023 ovf SHALL be 1 exactly when saturation clamps r.
REQ-024 OUT: out_valid=1; y and ovf SHALL hold stable until out_valid&out_ready, after which the FSM returns to IDLE with out_valid=0 on the next cycle.
REQ-025 Latency SHALL be: out_valid rises on the 2nd rising edge after the edge accepting the last beat, provided out_ready is irrelevant until then.
REQ-026 N_INPUTS=1 SHALL work: one beat, then FINAL, then OUT.
REQ-027 The accumulator SHALL NOT wrap for any input sequence when ACC_W meets REQ-002.
REQ-028 A start pulse and a downstream out_ready handshake in the same cycle in OUT SHALL return the FSM to IDLE only; that start is dropped.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, acc=0, counter=0, y=0, ovf=0, out_valid=0, in_ready=0, busy=0, including mid-ACCUM or mid-OUT; the partial evaluation is discarded.
REQ-030 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-031 Macro NEURON_MAC_ROUND_EN: when defined, FINAL SHALL compute r = (acc + 128) >>> 8 (round half up); when undefined, r = acc >>> 8 (truncate toward -inf). No other behaviour changes.

Verification
REQ-032 N=4, bias=0, x=256 (1.0), w=128 (0.5) all beats -> y=512 (2.0), ovf=0, out_valid on the 2nd edge after beat 4.
REQ-033 N=4, bias=-256, x=-256, w=256 all beats -> y=-1280 (-5.0), ovf=0; N=4, x=w=32767, bias=32767 -> y=32767, ovf=1; x=-32768, w=32767 -> y=-32768, ovf=1.
REQ-034 N=4, bias=0, x=1, w=160 -> acc=640; y=2 without NEURON_MAC_ROUND_EN, y=3 with it.
REQ-035 in_valid toggled 1/0 every cycle in ACCUM, then out_ready held low 5 cycles in OUT -> same y as contiguous case, y/ovf stable for all 5 cycles, in_ready=0, start pulses ignored.
REQ-036 rst_n pulsed low after beat 2 of 4 -> all outputs zero immediately; new start with x=256, w=256, bias=0 -> y=1024, no residue from the aborted run.

Source files
------------

// File: rtl/neuron_mac_q8_8.sv
// neuron_mac_q8_8 -- single-neuron Q8.8 multiply-accumulate with saturating output.
//
// Evaluates y = sat16(round_or_trunc((bias<<8 + sum_{i<N_INPUTS} x_i*w_i) >>> 8)).
// Sequence: IDLE -> ACCUM (N_INPUTS handshaked beats) -> FINAL (1 cycle) -> OUT.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin evaluation (IDLE only); bias sampled on the same edge
//   bias       signed Q8.8 bias
//   in_valid   x/w pair valid
//   in_ready   block accepts x/w pair (high in ACCUM)
//   x, w       signed Q8.8 activation / weight
//   out_valid  y valid (high in OUT)
//   out_ready  downstream accepts y
//   y          signed Q8.8 pre-activation result
//   ovf        y was saturated; qualified by out_valid
//   busy       state is not IDLE
//
// Build option: define NEURON_MAC_ROUND_EN for round-half-up in FINAL;
// otherwise the result is truncated toward -inf.
module neuron_mac_q8_8 #(
  parameter int unsigned N_INPUTS = 16,
  parameter int unsigned ACC_W    = 44
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y,
  output logic        ovf,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [15:0]               y_q, y_d;
  logic                      ovf_q, ovf_d;

  logic signed [31:0]        prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   acc_rnd;
  logic signed [ACC_W-1:0]   r_full;
  logic                      r_fits;
  logic                      beat;

  assign prod     = $signed(x) * $signed(w);
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  assign bias_ext = {{(ACC_W-16){bias[15]}}, bias} <<< 8;

`ifdef NEURON_MAC_ROUND_EN
  assign acc_rnd = acc_q + ACC_W'(128);
`else
  assign acc_rnd = acc_q;
`endif

  assign r_full = acc_rnd >>> 8;
  // r fits in 16 bits exactly when bits [ACC_W-1:15] are all copies of the sign.
  assign r_fits = (&r_full[ACC_W-1:15]) | ~(|r_full[ACC_W-1:15]);

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign beat      = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = FINAL;
        end
      end
      FINAL: begin
        ovf_d   = ~r_fits;
        y_d     = r_fits ? r_full[15:0] : (r_full[ACC_W-1] ? 16'h8000 : 16'h7FFF);
        state_d = OUT;
      end
      OUT: begin
        // A start coinciding with the handshake is dropped: only IDLE honours start.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_q8_8.sv
module tb_neuron_mac_q8_8;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] w = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] y;
  logic        ovf;
  logic        busy;

  neuron_mac_q8_8 #(.N_INPUTS(N), .ACC_W(44)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];   // {ovf, y}
  int n_pushed = 0;
  int n_popped = 0;

  logic signed [15:0] xa[N];
  logic signed [15:0] wa[N];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic on the Q16.16 sum, then shift and clamp.
  function automatic logic [16:0] model(input logic signed [15:0] b);
    longint acc, r;
    logic [15:0] yy;
    logic of;
    acc = longint'(b) * 256;
    for (int i = 0; i < N; i++) acc += longint'(xa[i]) * longint'(wa[i]);
`ifdef NEURON_MAC_ROUND_EN
    acc += 128;
`endif
    r = acc >>> 8;
    of = 1'b0;
    if (r > 32767) begin r = 32767; of = 1'b1; end
    else if (r < -32768) begin r = -32768; of = 1'b1; end
    yy = 16'(r);
    return {of, yy};
  endfunction

  // Monitor: pops one expectation on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got y=%0d with empty scoreboard", $signed(y));
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        n_popped++;
        chk("y", longint'($signed(y)), longint'($signed(e[15:0])));
        chk("ovf", longint'(ovf), longint'(e[16]));
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50 && busy; k++) @(negedge clk);
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic send_beat(input int i);
    int k;
    in_valid = 1'b1; x = xa[i]; w = wa[i];
    @(negedge clk);
    for (k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_eval(input logic signed [15:0] b, input bit gaps, input int hold);
    logic [15:0] yv;
    logic ov;
    wait_idle();
    exp_q.push_back(model(b));
    n_pushed++;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    start = 1'b1; bias = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gaps && i > 0) begin @(posedge clk); #1; end
      send_beat(i);
    end
    // One cycle in FINAL, then OUT on the second edge after the last beat.
    @(negedge clk);
    chk("lat_final_ov", out_valid, 0);
    chk("lat_final_ir", in_ready, 0);
    @(negedge clk);
    chk("lat_out_ov", out_valid, 1);
    yv = y; ov = ovf;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        start = (k % 2 == 0);
        @(negedge clk);
        chk("hold_y", y, yv);
        chk("hold_ovf", ovf, ov);
        chk("hold_ov", out_valid, 1);
        chk("hold_ir", in_ready, 0);
      end
      // start coincident with the handshake must not launch a new run.
      @(posedge clk); #1;
      start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_dropped_busy", busy, 0);
    end
    out_ready = 1'b1;
    wait_idle();
  endtask

  task automatic fill(input logic signed [15:0] xv, input logic signed [15:0] wv);
    for (int i = 0; i < N; i++) begin xa[i] = xv; wa[i] = wv; end
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    fill(16'sd256, 16'sd128);      do_eval(16'sd0, 0, 0);      // 2.0
    fill(-16'sd256, 16'sd256);     do_eval(-16'sd256, 0, 0);   // -5.0
    fill(16'sd32767, 16'sd32767);  do_eval(16'sd32767, 0, 0);  // +sat
    fill(-16'sd32768, 16'sd32767); do_eval(16'sd0, 0, 0);      // -sat
    fill(16'sd1, 16'sd160);        do_eval(16'sd0, 0, 0);      // 2 / 3 rounding
    fill(16'sd256, 16'sd128);      do_eval(16'sd0, 1, 5);      // stalls + held output

    // Abort after two beats: reset clears everything asynchronously.
    fill(16'sd1000, 16'sd1000);
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; bias = 16'sd100;
    @(posedge clk); #1;
    start = 1'b0;
    send_beat(0);
    send_beat(1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_y", y, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_ov", out_valid, 0);
    chk("abort_ir", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill(16'sd256, 16'sd256);      do_eval(16'sd0, 0, 0);      // 4.0, no residue

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          xa[i] = $urandom_range(0, 1) ? 16'sh7FFF : 16'sh8000;
          wa[i] = $urandom_range(0, 1) ? 16'sh7FFF : 16'sh8000;
        end else begin
          xa[i] = 16'($urandom);
          wa[i] = 16'($signed(16'($urandom)) >>> $urandom_range(0, 8));
        end
      end
      do_eval(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("outputs_seen", n_popped, n_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
